// File: rtl/pr_bx_sequencer_pkg.sv
// Shared definitions for the ProjectionRouter BX sequencer: the BX width,
// the default cycle budget and the sequencer state encoding.
package pr_bx_sequencer_pkg;

  // Width of the bunch-crossing identifier carried to the ProjectionRouter
  localparam int BX_W = 3;

  // Default cycle budget for one ProjectionRouter run
  localparam int MAX_CYCLES_DEF = 120;

  // Sequencer states
  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_GAP  = 2'd2
  } seq_state_e;

  // Next BX value; the 3-bit field wraps naturally from 7 back to 0
  function automatic logic [BX_W-1:0] bx_inc(input logic [BX_W-1:0] bx);
    return bx + BX_W'(1);
  endfunction

endpackage

// File: rtl/pr_bx_sequencer.sv
// Launches one ProjectionRouter run per BX event, holds one event in reserve
// while a run is active, enforces a cycle budget per run and keeps sticky
// error flags for dropped events, timeouts and BX mismatches on completion.
module pr_bx_sequencer
  import pr_bx_sequencer_pkg::*;
#(
  parameter int              MAX_CYCLES = MAX_CYCLES_DEF,
  parameter logic [BX_W-1:0] BX_INIT    = 3'd0
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            run_en,
  input  logic            ev_valid,
  input  logic            err_clr,
  input  logic            pr_done,
  input  logic [BX_W-1:0] pr_bx_out,
  output logic            en_proc,
  output logic [BX_W-1:0] bx_in,
  output logic            busy,
  output logic            bx_done,
  output logic [BX_W-1:0] bx_done_id,
  output logic            err_overrun,
  output logic            err_timeout,
  output logic            err_bxmis
);

  localparam int              CYC_W    = $clog2(MAX_CYCLES + 1);
  localparam logic [CYC_W-1:0] CYC_ONE  = CYC_W'(1);
  // Counter value in the last permitted RUN cycle; without pr_done there the
  // counter reaches MAX_CYCLES and the run is abandoned.
  localparam logic [CYC_W-1:0] CYC_LAST = CYC_W'(MAX_CYCLES - 1);

  seq_state_e       r_state;
  logic             r_pend;
  logic [CYC_W-1:0] r_cyc;
  logic [BX_W-1:0]  r_bx_cnt;
  logic             r_en_proc;
  logic [BX_W-1:0]  r_bx_in;
  logic             r_busy;
  logic             r_bx_done;
  logic [BX_W-1:0]  r_bx_done_id;
  logic             r_err_overrun;
  logic             r_err_timeout;
  logic             r_err_bxmis;

  logic w_ev_acc;
  logic w_in_run;
  logic w_run_or_gap;
  logic w_tmo_hit;
  logic w_ovr_set;
  logic w_mis_set;

  // Event qualification and error-event detection for the current cycle
  assign w_ev_acc     = ev_valid & run_en;
  assign w_in_run     = (r_state == ST_RUN);
  assign w_run_or_gap = (r_state == ST_RUN) | (r_state == ST_GAP);
  assign w_tmo_hit    = w_in_run & ~pr_done & (r_cyc == CYC_LAST);
  assign w_ovr_set    = w_ev_acc & r_pend & w_run_or_gap;
  assign w_mis_set    = w_in_run & pr_done & (pr_bx_out != r_bx_in);

  // Sequencer FSM with pending slot, cycle budget, BX counter and run outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state      <= ST_IDLE;
      r_pend       <= 1'b0;
      r_cyc        <= '0;
      r_bx_cnt     <= BX_INIT;
      r_en_proc    <= 1'b0;
      r_bx_in      <= BX_INIT;
      r_busy       <= 1'b0;
      r_bx_done    <= 1'b0;
      r_bx_done_id <= 3'd0;
    end else begin
      r_bx_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_ev_acc) begin
            r_state   <= ST_RUN;
            r_en_proc <= 1'b1;
            r_bx_in   <= r_bx_cnt;
            r_cyc     <= '0;
            r_busy    <= 1'b1;
          end else begin
            r_en_proc <= 1'b0;
            r_busy    <= 1'b0;
          end
          r_pend <= 1'b0;
        end

        ST_RUN: begin
          if (pr_done) begin
            // Normal completion: report the BX that was presented for this run
            r_state      <= ST_GAP;
            r_en_proc    <= 1'b0;
            r_bx_done    <= 1'b1;
            r_bx_done_id <= r_bx_in;
            r_bx_cnt     <= bx_inc(r_bx_cnt);
          end else if (w_tmo_hit) begin
            // Budget exhausted: abandon the run silently and move to the next BX
            r_state   <= ST_GAP;
            r_en_proc <= 1'b0;
            r_bx_cnt  <= bx_inc(r_bx_cnt);
            r_cyc     <= r_cyc + CYC_ONE;
          end else begin
            r_cyc <= r_cyc + CYC_ONE;
          end
          // Losing run_en discards any reserved event; a second event is dropped
          if (!run_en) begin
            r_pend <= 1'b0;
          end else if (ev_valid) begin
            r_pend <= 1'b1;
          end else begin
            r_pend <= r_pend;
          end
          r_busy <= 1'b1;
        end

        ST_GAP: begin
          // An event arriving during the gap is taken as the pending one
          if (run_en && (r_pend || ev_valid)) begin
            r_state   <= ST_RUN;
            r_en_proc <= 1'b1;
            r_bx_in   <= r_bx_cnt;
            r_cyc     <= '0;
            r_busy    <= 1'b1;
          end else begin
            r_state   <= ST_IDLE;
            r_en_proc <= 1'b0;
            r_busy    <= 1'b0;
          end
          r_pend <= 1'b0;
        end

        default: begin
          r_state   <= ST_IDLE;
          r_pend    <= 1'b0;
          r_en_proc <= 1'b0;
          r_busy    <= 1'b0;
        end
      endcase
    end
  end

  // Sticky error flags: a new error event outranks a same-cycle clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_err_overrun <= 1'b0;
      r_err_timeout <= 1'b0;
      r_err_bxmis   <= 1'b0;
    end else begin
      r_err_overrun <= w_ovr_set | (r_err_overrun & ~err_clr);
      r_err_timeout <= w_tmo_hit | (r_err_timeout & ~err_clr);
      r_err_bxmis   <= w_mis_set | (r_err_bxmis & ~err_clr);
    end
  end

  assign en_proc     = r_en_proc;
  assign bx_in       = r_bx_in;
  assign busy        = r_busy;
  assign bx_done     = r_bx_done;
  assign bx_done_id  = r_bx_done_id;
  assign err_overrun = r_err_overrun;
  assign err_timeout = r_err_timeout;
  assign err_bxmis   = r_err_bxmis;

endmodule

// File: tb/tb_pr_bx_sequencer.sv
// Directed bench for pr_bx_sequencer: single run timing, back-to-back runs
// with BX wrap, overrun, timeout, BX mismatch, ignored inputs and mid-run reset.
module tb_pr_bx_sequencer;

  logic       clk = 1'b0;
  logic       reset;
  logic       run_en;
  logic       ev_valid;
  logic       err_clr;
  logic       pr_done;
  logic [2:0] pr_bx_out;
  logic       en_proc;
  logic [2:0] bx_in;
  logic       busy;
  logic       bx_done;
  logic [2:0] bx_done_id;
  logic       err_overrun;
  logic       err_timeout;
  logic       err_bxmis;

  int n_checks = 0;
  int n_errors = 0;
  int n_done   = 0;

  // 10 time-unit clock
  always #5 clk = ~clk;

  pr_bx_sequencer #(.MAX_CYCLES(120), .BX_INIT(3'd0)) dut (
    .clk        (clk),
    .reset      (reset),
    .run_en     (run_en),
    .ev_valid   (ev_valid),
    .err_clr    (err_clr),
    .pr_done    (pr_done),
    .pr_bx_out  (pr_bx_out),
    .en_proc    (en_proc),
    .bx_in      (bx_in),
    .busy       (busy),
    .bx_done    (bx_done),
    .bx_done_id (bx_done_id),
    .err_overrun(err_overrun),
    .err_timeout(err_timeout),
    .err_bxmis  (err_bxmis)
  );

  // Count completion strobes away from the active edge
  always @(negedge clk) begin
    if (bx_done) n_done <= n_done + 1;
  end

  task automatic check(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic launch();
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
  endtask

  task automatic finish_run(input logic [2:0] pbx);
    pr_bx_out = pbx;
    pr_done   = 1'b1;
    tick();
    pr_done   = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin
    int hi;
    int cnt;
    int d0;
    reset     = 1'b0;
    run_en    = 1'b1;
    ev_valid  = 1'b0;
    err_clr   = 1'b0;
    pr_done   = 1'b0;
    pr_bx_out = 3'd0;

    // Reset state
    tick();
    check("rst_en_proc", int'(en_proc), 0);
    check("rst_bx_in", int'(bx_in), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_bx_done", int'(bx_done), 0);
    check("rst_done_id", int'(bx_done_id), 0);
    check("rst_errs", int'({err_overrun, err_timeout, err_bxmis}), 0);

    // Single run: event in cycle 10, pr_done in cycle 60
    reset = 1'b1;
    repeat (8) tick();
    launch();
    check("one_en", int'(en_proc), 1);
    check("one_bx_in", int'(bx_in), 0);
    check("one_busy", int'(busy), 1);
    hi = 1;
    repeat (49) begin
      tick();
      if (en_proc) hi++;
    end
    check("one_len", hi, 50);
    finish_run(3'd0);
    check("one_en_drop", int'(en_proc), 0);
    check("one_done", int'(bx_done), 1);
    check("one_id", int'(bx_done_id), 0);
    tick();
    check("one_pulse", int'(bx_done), 0);
    check("one_idle", int'(busy), 0);
    launch();
    check("one_next_bx", int'(bx_in), 1);
    finish_run(3'd1);
    tick();

    // Nine back-to-back runs, BX sequence 0..7,0
    do_reset();
    d0 = n_done;
    launch();
    for (int k = 0; k < 9; k++) begin
      check("b2b_en", int'(en_proc), 1);
      check("b2b_bx_in", int'(bx_in), k % 8);
      tick();
      tick();
      if (k < 8) begin
        ev_valid = 1'b1;
        tick();
        ev_valid = 1'b0;
      end
      finish_run(3'(k % 8));
      check("b2b_done", int'(bx_done), 1);
      check("b2b_id", int'(bx_done_id), k % 8);
      check("b2b_gap", int'(en_proc), 0);
      tick();
    end
    check("b2b_idle_en", int'(en_proc), 0);
    check("b2b_idle", int'(busy), 0);
    check("b2b_ndone", n_done - d0, 9);
    check("b2b_noerr", int'({err_overrun, err_bxmis}), 0);

    // Overrun: second event pended, third dropped
    do_reset();
    d0 = n_done;
    launch();
    tick();
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    check("ovr_pend_ok", int'(err_overrun), 0);
    tick();
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    check("ovr_set", int'(err_overrun), 1);
    ev_valid = 1'b1;
    err_clr  = 1'b1;
    tick();
    ev_valid = 1'b0;
    err_clr  = 1'b0;
    check("ovr_clr_race", int'(err_overrun), 1);
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("ovr_clr", int'(err_overrun), 0);
    finish_run(3'd0);
    tick();
    check("ovr_second_en", int'(en_proc), 1);
    check("ovr_second_bx", int'(bx_in), 1);
    tick();
    finish_run(3'd1);
    repeat (3) tick();
    check("ovr_ndone", n_done - d0, 2);
    check("ovr_idle", int'(busy), 0);

    // Timeout after 120 RUN cycles
    do_reset();
    d0 = n_done;
    launch();
    cnt = 0;
    while (en_proc && cnt < 200) begin
      cnt++;
      tick();
    end
    check("tmo_len", cnt, 120);
    check("tmo_flag", int'(err_timeout), 1);
    check("tmo_nodone", n_done - d0, 0);
    tick();
    launch();
    check("tmo_bx_adv", int'(bx_in), 1);
    finish_run(3'd1);
    tick();

    // BX mismatch at completion, then clear
    launch();
    check("mis_bx_in", int'(bx_in), 2);
    tick();
    finish_run(3'd5);
    check("mis_flag", int'(err_bxmis), 1);
    check("mis_done", int'(bx_done), 1);
    check("mis_id", int'(bx_done_id), 2);
    tick();
    err_clr = 1'b1;
    tick();
    err_clr = 1'b0;
    check("mis_clr", int'(err_bxmis), 0);
    check("tmo_clr", int'(err_timeout), 0);

    // Ignored inputs and run_en falling mid-run
    run_en   = 1'b0;
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    check("ign_en", int'(en_proc), 0);
    check("ign_busy", int'(busy), 0);
    check("ign_ovr", int'(err_overrun), 0);
    run_en = 1'b1;
    d0 = n_done;
    pr_done = 1'b1;
    tick();
    pr_done = 1'b0;
    tick();
    check("ign_prdone", n_done - d0, 0);
    launch();
    check("ren_bx_in", int'(bx_in), 3);
    ev_valid = 1'b1;
    tick();
    ev_valid = 1'b0;
    run_en   = 1'b0;
    tick();
    finish_run(3'd3);
    check("ren_done", int'(bx_done), 1);
    tick();
    check("ren_no_relaunch", int'(en_proc), 0);
    check("ren_idle", int'(busy), 0);
    run_en = 1'b1;

    // Asynchronous reset in the middle of a run
    launch();
    check("arst_bx_in", int'(bx_in), 4);
    tick();
    tick();
    d0 = n_done;
    #2;
    reset = 1'b0;
    #1;
    check("arst_en", int'(en_proc), 0);
    check("arst_busy", int'(busy), 0);
    pr_done   = 1'b1;
    pr_bx_out = 3'd4;
    tick();
    tick();
    pr_done = 1'b0;
    check("arst_nodone", n_done - d0, 0);
    reset = 1'b1;
    tick();
    launch();
    check("arst_bx_init", int'(bx_in), 0);
    finish_run(3'd0);
    tick();

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
